// File: rtl/neurex_pkg.sv
// Shared types and helpers for the operand skew feeder: FSM state encoding
// and the width of the beat counters derived from the dimension width.
package neurex_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } feeder_state_t;

   // Dimension products (and hence beat counts) need twice the dimension width.
   function automatic int beat_cnt_w(input int dim_w);
      return 2 * dim_w;
   endfunction

endpackage

// File: rtl/operand_skew_feeder_if.sv
// Operand beat streams into the feeder and the skewed row/column feed out of it.
interface operand_skew_feeder_if #(
   parameter int SYS_ROW    = 4,
   parameter int SYS_COL    = 4,
   parameter int DATA_WIDTH = 16
);
   logic                                 in_valid;
   logic                                 in_ready;
   logic [SYS_ROW-1:0][DATA_WIDTH-1:0]   in_data;
   logic                                 w_valid;
   logic                                 w_ready;
   logic [SYS_COL-1:0][DATA_WIDTH-1:0]   w_data;
   logic [SYS_ROW-1:0]                   arr_in_en;
   logic [SYS_ROW-1:0][DATA_WIDTH-1:0]   arr_in_data;
   logic [SYS_COL-1:0]                   arr_w_en;
   logic [SYS_COL-1:0][DATA_WIDTH-1:0]   arr_w_data;

   modport master (
      output in_valid, in_data, w_valid, w_data,
      input  in_ready, w_ready, arr_in_en, arr_in_data, arr_w_en, arr_w_data
   );

   modport slave (
      input  in_valid, in_data, w_valid, w_data,
      output in_ready, w_ready, arr_in_en, arr_in_data, arr_w_en, arr_w_data
   );
endinterface

// File: rtl/skew_line.sv
// Fixed-depth delay line for one array lane; data is forced to zero whenever
// the lane carries no beat so idle slots reach the array as en=0, data=0.
module skew_line #(
   parameter int DEPTH      = 1,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  en_out,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DEPTH-1:0]                 en_p;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] data_p;

   always_ff @(posedge clk) begin
      if (rst) begin
         en_p   <= '0;
         data_p <= '0;
      end else begin
         en_p[0]   <= en_in;
         data_p[0] <= en_in ? data_in : '0;
         for (int i = 1; i < DEPTH; i++) begin
            en_p[i]   <= en_p[i-1];
            data_p[i] <= data_p[i-1];
         end
      end
   end

   assign en_out   = en_p[DEPTH-1];
   assign data_out = data_p[DEPTH-1];

endmodule

// File: rtl/operand_skew_feeder.sv
// Accepts input/weight operand beats for an M x K x N job and feeds them to a
// systolic array with lane k delayed k+1 cycles, then drains and reports done.
module operand_skew_feeder
   import neurex_pkg::*;
#(
   parameter int SYS_ROW    = 4,
   parameter int SYS_COL    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int DIM_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIM_WIDTH-1:0] num_in,
   input  logic [DIM_WIDTH-1:0] num_common,
   input  logic [DIM_WIDTH-1:0] num_out,
   input  logic                 start,
   operand_skew_feeder_if.slave bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int CNT_W     = beat_cnt_w(DIM_WIDTH);
   localparam int ROW_SH    = $clog2(SYS_ROW);
   localparam int COL_SH    = $clog2(SYS_COL);
   localparam int DRAIN_LEN = (SYS_ROW > SYS_COL) ? SYS_ROW : SYS_COL;
   localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

   feeder_state_t state, state_n;

   logic                 pend;
   logic [DIM_WIDTH-1:0] m_q, k_q, n_q;
   logic [CNT_W-1:0]     in_prod, w_prod, in_total, w_total;
   logic [CNT_W-1:0]     in_cnt, w_cnt, in_cnt_n, w_cnt_n;
   logic [DRAIN_W-1:0]   drain_cnt;
   logic                 err_q;
   logic                 dim_bad;
   logic                 start_acc;
   logic                 in_rdy, w_rdy, in_acc, w_acc;
   logic [SYS_ROW-1:0]                 row_en;
   logic [SYS_ROW-1:0][DATA_WIDTH-1:0] row_data;
   logic [SYS_COL-1:0]                 col_en;
   logic [SYS_COL-1:0][DATA_WIDTH-1:0] col_data;

   // Job sizing from the latched dimensions; lane counts are powers of two.
   assign in_prod  = CNT_W'(m_q) * CNT_W'(k_q);
   assign w_prod   = CNT_W'(k_q) * CNT_W'(n_q);
   assign in_total = in_prod >> ROW_SH;
   assign w_total  = w_prod >> COL_SH;
   assign dim_bad  = (m_q == '0) || (k_q == '0) || (n_q == '0) ||
                     (in_prod[ROW_SH-1:0] != '0) || (w_prod[COL_SH-1:0] != '0);

   assign start_acc = start && (state == IDLE) && !pend;
   assign in_rdy    = (state == LOAD) && (in_cnt < in_total);
   assign w_rdy     = (state == LOAD) && (w_cnt < w_total);
   assign in_acc    = bus.in_valid && in_rdy;
   assign w_acc     = bus.w_valid && w_rdy;
   assign in_cnt_n  = in_cnt + CNT_W'(in_acc);
   assign w_cnt_n   = w_cnt + CNT_W'(w_acc);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (pend) state_n = dim_bad ? DONE : LOAD;
         LOAD:    if ((in_cnt_n == in_total) && (w_cnt_n == w_total)) state_n = DRAIN;
         DRAIN:   if (drain_cnt == DRAIN_W'(DRAIN_LEN - 1)) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // A start in IDLE spends one cycle pending so the products settle from the
   // latched dimensions before the job is validated.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pend      <= 1'b0;
         m_q       <= '0;
         k_q       <= '0;
         n_q       <= '0;
         in_cnt    <= '0;
         w_cnt     <= '0;
         drain_cnt <= '0;
         err_q     <= 1'b0;
      end else begin
         state <= state_n;
         if (start_acc) begin
            m_q    <= num_in;
            k_q    <= num_common;
            n_q    <= num_out;
            pend   <= 1'b1;
            err_q  <= 1'b0;
            in_cnt <= '0;
            w_cnt  <= '0;
         end else begin
            if (pend) begin
               pend  <= 1'b0;
               err_q <= dim_bad;
            end
            in_cnt <= in_cnt_n;
            w_cnt  <= w_cnt_n;
         end
         if (state == DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
         else                drain_cnt <= '0;
      end
   end

   // Per-lane skew: lane k is delayed k+1 cycles after acceptance.
   for (genvar k = 0; k < SYS_ROW; k++) begin : g_row
      skew_line #(.DEPTH(k + 1), .DATA_WIDTH(DATA_WIDTH)) u_line (
         .clk      (clk),
         .rst      (rst),
         .en_in    (in_acc),
         .data_in  (bus.in_data[k]),
         .en_out   (row_en[k]),
         .data_out (row_data[k])
      );
   end

   for (genvar k = 0; k < SYS_COL; k++) begin : g_col
      skew_line #(.DEPTH(k + 1), .DATA_WIDTH(DATA_WIDTH)) u_line (
         .clk      (clk),
         .rst      (rst),
         .en_in    (w_acc),
         .data_in  (bus.w_data[k]),
         .en_out   (col_en[k]),
         .data_out (col_data[k])
      );
   end

   assign bus.in_ready    = in_rdy;
   assign bus.w_ready     = w_rdy;
   assign bus.arr_in_en   = row_en;
   assign bus.arr_in_data = row_data;
   assign bus.arr_w_en    = col_en;
   assign bus.arr_w_data  = col_data;

   assign busy = (state == LOAD) || (state == DRAIN);
   assign done = (state == DONE);
   assign err  = err_q;

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Directed bench for operand_skew_feeder: job-table sweep plus hand-written
// skew, bubble, reset-abort and error sequences.
module tb_operand_skew_feeder;

   localparam int SR = 4;
   localparam int SC = 4;
   localparam int DW = 16;
   localparam int MW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [MW-1:0] num_in, num_common, num_out;
   logic          start;
   logic          busy, done, err;

   int checks = 0;
   int errors = 0;

   operand_skew_feeder_if #(.SYS_ROW(SR), .SYS_COL(SC), .DATA_WIDTH(DW)) bus ();

   operand_skew_feeder #(
      .SYS_ROW(SR), .SYS_COL(SC), .DATA_WIDTH(DW), .DIM_WIDTH(MW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .num_in     (num_in),
      .num_common (num_common),
      .num_out    (num_out),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int m, k, n;
      int poke;
      bit exp_err;
      int exp_in, exp_w;
      int exp_lat;
   } vec_t;

   vec_t vecs[9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs_vec();
      return 64'({bus.in_ready, bus.w_ready, busy, done, err, bus.arr_in_en,
                  bus.arr_w_en, |bus.arr_in_data, |bus.arr_w_data});
   endfunction

   task automatic run_job(input vec_t v, output int in_b, output int w_b, output int lat,
                          output int drain_d, output bit err_at_done, output bit rdy_seen,
                          output bit done_seen, output bit done_one);
      int drain_s;
      bit poked;
      in_b = 0; w_b = 0; lat = -1; drain_d = -1; drain_s = -1;
      err_at_done = 1'b0; rdy_seen = 1'b0; done_seen = 1'b0; poked = 1'b0;
      bus.in_valid = 1'b1;
      bus.w_valid  = 1'b1;
      num_in = MW'(v.m); num_common = MW'(v.k); num_out = MW'(v.n);
      start = 1'b1;
      for (int t = 1; t <= 400 && !done_seen; t++) begin
         if (bus.in_valid && bus.in_ready) in_b++;
         if (bus.w_valid && bus.w_ready) w_b++;
         rdy_seen |= bus.in_ready | bus.w_ready;
         if (v.poke >= 0 && !poked && in_b == v.poke) begin
            start = 1'b1;
            num_in = 16'd4; num_common = 16'd4; num_out = 16'd4;
            poked = 1'b1;
         end
         tick();
         start = 1'b0;
         if (busy && !bus.in_ready && !bus.w_ready && drain_s < 0) drain_s = t;
         if (done) begin
            done_seen   = 1'b1;
            lat         = t;
            err_at_done = err;
            if (drain_s >= 0) drain_d = t - drain_s;
         end
      end
      bus.in_valid = 1'b0;
      bus.w_valid  = 1'b0;
      tick();
      done_one = !done && !busy;
   endtask

   initial begin
      int in_b, w_b, lat, drain_d;
      bit e_done, rdy_seen, done_seen, done_one;
      bit ok;
      logic [5:0] e0, e2;

      vecs[0] = '{m: 8, k: 8, n: 16, poke: -1, exp_err: 0, exp_in: 16, exp_w: 32, exp_lat: 38};
      vecs[1] = '{m: 0, k: 8, n: 8,  poke: -1, exp_err: 1, exp_in: 0,  exp_w: 0,  exp_lat: 2};
      vecs[2] = '{m: 3, k: 1, n: 4,  poke: -1, exp_err: 1, exp_in: 0,  exp_w: 0,  exp_lat: 2};
      vecs[3] = '{m: 4, k: 1, n: 4,  poke: -1, exp_err: 0, exp_in: 1,  exp_w: 1,  exp_lat: 7};
      vecs[4] = '{m: 2, k: 2, n: 2,  poke: -1, exp_err: 0, exp_in: 1,  exp_w: 1,  exp_lat: 7};
      vecs[5] = '{m: 4, k: 4, n: 0,  poke: -1, exp_err: 1, exp_in: 0,  exp_w: 0,  exp_lat: 2};
      vecs[6] = '{m: 1, k: 4, n: 3,  poke: -1, exp_err: 0, exp_in: 1,  exp_w: 3,  exp_lat: 9};
      vecs[7] = '{m: 2, k: 3, n: 4,  poke: -1, exp_err: 1, exp_in: 0,  exp_w: 0,  exp_lat: 2};
      vecs[8] = '{m: 8, k: 8, n: 16, poke: 3,  exp_err: 0, exp_in: 16, exp_w: 32, exp_lat: 38};

      rst = 1'b1; start = 1'b0;
      num_in = '0; num_common = '0; num_out = '0;
      bus.in_valid = 1'b0; bus.w_valid = 1'b0;
      bus.in_data = '0; bus.w_data = '0;
      tick(); tick();
      chk("reset_outputs", outs_vec(), 64'd0);
      rst = 1'b0;
      tick();
      chk("idle_outputs", outs_vec(), 64'd0);

      // Job table sweep
      foreach (vecs[i]) begin
         run_job(vecs[i], in_b, w_b, lat, drain_d, e_done, rdy_seen, done_seen, done_one);
         chk($sformatf("v%0d_done_seen", i), 64'(done_seen), 64'd1);
         chk($sformatf("v%0d_in_beats", i), 64'(in_b), 64'(vecs[i].exp_in));
         chk($sformatf("v%0d_w_beats", i), 64'(w_b), 64'(vecs[i].exp_w));
         chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         chk($sformatf("v%0d_err", i), 64'(e_done), 64'(vecs[i].exp_err));
         chk($sformatf("v%0d_ready_seen", i), 64'(rdy_seen), 64'(!vecs[i].exp_err));
         chk($sformatf("v%0d_drain_len", i), 64'(drain_d), vecs[i].exp_err ? 64'(-1) : 64'd4);
         chk($sformatf("v%0d_done_one_cycle", i), 64'(done_one), 64'd1);
         tick();
      end

      // Skew of a single input beat, then w_valid bubbles 1,0,1
      num_in = 16'd8; num_common = 16'd8; num_out = 16'd16;
      start = 1'b1;
      tick();
      start = 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 10 && !ok; t++) begin
         if (bus.in_ready) ok = 1'b1;
         else tick();
      end
      chk("skew_ready_wait", 64'(ok), 64'd1);
      for (int k = 0; k < SR; k++) bus.in_data[k] = DW'(k + 1);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("skew_lane3_idle_data", 64'(bus.arr_in_data[3]), 64'd0);
      for (int k = 0; k < SR; k++) begin
         if (k > 0) tick();
         chk($sformatf("skew_en_plus%0d", k + 1), 64'(bus.arr_in_en), 64'(1 << k));
         chk($sformatf("skew_data_lane%0d", k), 64'(bus.arr_in_data[k]), 64'(k + 1));
      end
      tick();
      chk("skew_en_after", 64'(bus.arr_in_en), 64'd0);

      for (int k = 0; k < SC; k++) bus.w_data[k] = DW'(16 + k);
      bus.w_valid = 1'b1;
      e0 = '0; e2 = '0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) bus.w_valid = 1'b0;
         if (i == 1) bus.w_valid = 1'b1;
         if (i == 2) bus.w_valid = 1'b0;
         e0[i] = bus.arr_w_en[0];
         e2[i] = bus.arr_w_en[2];
      end
      chk("bubble_lane0", 64'(e0), 64'b000101);
      chk("bubble_lane2", 64'(e2), 64'b010100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Reset at beat 5 aborts the job
      num_in = 16'd8; num_common = 16'd8; num_out = 16'd16;
      bus.in_valid = 1'b1; bus.w_valid = 1'b1;
      start = 1'b1;
      in_b = 0;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
         if (bus.in_valid && bus.in_ready) in_b++;
         tick();
         start = 1'b0;
         if (in_b == 5) ok = 1'b1;
      end
      chk("rst_reached_beat5", 64'(ok), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.in_valid = 1'b0; bus.w_valid = 1'b0;
      chk("rst_midjob_outputs", outs_vec(), 64'd0);
      done_seen = 1'b0;
      for (int t = 0; t < 20; t++) begin
         tick();
         done_seen |= done;
      end
      chk("rst_no_done", 64'(done_seen), 64'd0);
      run_job(vecs[3], in_b, w_b, lat, drain_d, e_done, rdy_seen, done_seen, done_one);
      chk("post_rst_done", 64'(done_seen), 64'd1);
      chk("post_rst_latency", 64'(lat), 64'd7);
      chk("post_rst_err", 64'(e_done), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_skew_feeder.md
OPERAND_SKEW_FEEDER -- requirements
Module: operand_skew_feeder

Interface
REQ-001 SHALL have parameter SYS_ROW, default 4: input-operand lane count; power of two, at least 2.
REQ-002 SHALL have parameter SYS_COL, default 4: weight-operand lane count; power of two, at least 2.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: operand element width.
REQ-004 SHALL have parameter DIM_WIDTH, default 16: matrix dimension field width.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have ports num_in / num_common / num_out, input, DIM_WIDTH each: M, K, N of the job; sampled on start.
REQ-008 SHALL have port start, input, 1: one-cycle job request.
REQ-009 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, SYS_ROW x DATA_WIDTH): input-operand beat stream.
REQ-010 SHALL have ports w_valid (input, 1), w_ready (output, 1) and w_data (input, SYS_COL x DATA_WIDTH): weight beat stream.
REQ-011 SHALL have ports arr_in_en (output, SYS_ROW) and arr_in_data (output, SYS_ROW x DATA_WIDTH): skewed row feed to the array.
REQ-012 SHALL have ports arr_w_en (output, SYS_COL) and arr_w_data (output, SYS_COL x DATA_WIDTH): skewed column feed to the array.
REQ-013 SHALL have ports busy, done and err, output, 1 each: job active; one-cycle completion pulse; error flag, valid while done=1.

Function
REQ-014 SHALL implement states IDLE, LOAD, DRAIN, DONE.
REQ-015 IDLE + start SHALL latch the dimensions and go to LOAD; start in any other state SHALL be ignored.
REQ-016 Input beat total SHALL be (num_in*num_common)/SYS_ROW and weight beat total (num_common*num_out)/SYS_COL; products and counters 2*DIM_WIDTH bits.
REQ-017 A dimension of zero, or a product not divisible by its lane count, SHALL send IDLE directly to DONE with err=1 and no beats accepted.
REQ-018 in_ready SHALL be 1 only in LOAD while the input count is below its total; likewise w_ready for the weight count; streams are independent.
REQ-019 A beat SHALL be accepted on valid&&ready; its count SHALL increment by exactly 1 per accepted beat.
REQ-020 An accepted beat's lane k SHALL appear on arr_*_data[k] with arr_*_en[k]=1 exactly k+1 cycles after acceptance; the lane with no beat SHALL drive en=0 and data=0.
REQ-021 The stream bubble pattern SHALL be preserved per lane (no compaction).
REQ-022 LOAD SHALL go to DRAIN on the cycle both counts reach their totals, including on the same cycle.
REQ-023 DRAIN SHALL last max(SYS_ROW,SYS_COL) cycles, then go to DONE.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE; start during DONE is ignored.
REQ-025 busy SHALL be 1 in LOAD and DRAIN, otherwise 0.
REQ-026 err SHALL clear on the next accepted start.

Reset
REQ-027 rst=1 SHALL force IDLE, clear counters and all skew registers, and drive in_ready, w_ready, arr_*_en, arr_*_data, busy, done and err to 0.
REQ-028 rst mid-job SHALL abort the job with no done pulse; skewed data in flight SHALL be discarded.

Structure
REQ-029 The state enum and the beat-count width function SHALL be placed in the shared package neurex_pkg.
REQ-030 The per-lane delay SHALL be the sub-module skew_line, parameterised by delay depth and DATA_WIDTH and carrying en and data; it SHALL be instantiated once per lane.

Verification
REQ-031 Bench SHALL cover, with SYS_ROW=SYS_COL=4 and M=8, K=8, N=16 and both valids held high: exactly 16 input beats and 32 weight beats accepted; in_ready falls after 16; done pulses 4 cycles after DRAIN entry; err=0.
REQ-032 Bench SHALL cover skew: for the first accepted input beat {1,2,3,4}, arr_in_data[0]=1 at +1 cycle and arr_in_data[3]=4 at +4 cycles, with en high for only that cycle.
REQ-033 Bench SHALL cover bubbles: toggling w_valid 1,0,1 yields arr_w_en[0] pattern 1,0,1 and arr_w_en[2] showing the same pattern 2 cycles later.
REQ-034 Bench SHALL cover errors: M=0 gives done with err=1 two cycles after start, and neither ready is ever 1; M=3, K=1 also gives err=1.
REQ-035 Bench SHALL cover reset: rst asserted at beat 5 leaves all outputs 0 the next cycle, no done follows, and a new start then completes normally.
REQ-036 Bench SHALL cover start while busy: a start pulse during LOAD leaves counts and the dimensions unchanged.
